// File: rtl/pep_regf_rd_arb.sv
// Round-robin arbiter sharing the PE regfile read port between NREQ requesters.
// Tracks the owner of each accepted request and steers returned data back to it.
module pep_regf_rd_arb #(
    parameter int NREQ          = 2,
    parameter int REGF_RD_REQ_W = 32,
    parameter int REGF_COEF_NB  = 4,
    parameter int MOD_Q_W       = 32,
    parameter int OUTST_DEPTH   = 4
) (
    input  logic                                       clk,
    input  logic                                       a_rst_n,
    input  logic [NREQ-1:0]                            req_vld,
    output logic [NREQ-1:0]                            req_rdy,
    input  logic [NREQ-1:0][REGF_RD_REQ_W-1:0]         req,
    output logic                                       regf_rd_req_vld,
    input  logic                                       regf_rd_req_rdy,
    output logic [REGF_RD_REQ_W-1:0]                   regf_rd_req,
    input  logic [REGF_COEF_NB-1:0]                    regf_rd_data_avail,
    input  logic [REGF_COEF_NB-1:0][MOD_Q_W-1:0]       regf_rd_data,
    input  logic                                       regf_rd_last_word,
    input  logic                                       regf_rd_is_body,
    input  logic                                       regf_rd_last_mask,
    output logic [NREQ-1:0][REGF_COEF_NB-1:0]          rd_data_avail,
    output logic [REGF_COEF_NB-1:0][MOD_Q_W-1:0]       rd_data,
    output logic                                       rd_last_word,
    output logic                                       rd_is_body,
    output logic                                       rd_last_mask,
    output logic                                       err_unexp_data
);

    localparam int OWN_W = $clog2(NREQ);
    localparam int AW    = $clog2(OUTST_DEPTH);
    localparam int CW    = AW + 1;

    logic                     r_slot_vld;
    logic [REGF_RD_REQ_W-1:0] r_slot_req;
    logic [OWN_W-1:0]         r_slot_owner;
    logic [OWN_W-1:0]         r_rr_ptr;

    logic [OWN_W-1:0]         r_owner_mem [OUTST_DEPTH];
    logic [AW-1:0]            r_wr_ptr;
    logic [AW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_cnt;

    logic [NREQ-1:0][REGF_COEF_NB-1:0]    r_rd_data_avail;
    logic [REGF_COEF_NB-1:0][MOD_Q_W-1:0] r_rd_data;
    logic                                 r_rd_last_word;
    logic                                 r_rd_is_body;
    logic                                 r_rd_last_mask;
    logic                                 r_err;

    logic                              w_gnt_found;
    logic [OWN_W-1:0]                  w_gnt_idx;
    logic [OWN_W-1:0]                  w_scan;
    logic                              w_can_grant;
    logic                              w_grant;
    logic                              w_push;
    logic                              w_pop;
    logic                              w_empty;
    logic [OWN_W-1:0]                  w_head;
    logic [NREQ-1:0][REGF_COEF_NB-1:0] w_steer;

    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = OWN_W'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_gnt_found && req_vld[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan;
            end
        end
    end

    // Reset gates the grant so req_rdy is low the moment reset asserts.
    assign w_can_grant = a_rst_n && !r_slot_vld && (r_cnt < CW'(OUTST_DEPTH));
    assign w_grant     = w_can_grant && w_gnt_found;

    always_comb begin
        req_rdy = '0;
        if (w_grant) req_rdy[w_gnt_idx] = 1'b1;
    end

    assign w_push  = r_slot_vld && regf_rd_req_rdy;
    assign w_empty = (r_cnt == '0);
    assign w_pop   = regf_rd_data_avail[0] && regf_rd_last_word && !w_empty;
    assign w_head  = r_owner_mem[r_rd_ptr];

    always_comb begin
        w_steer = '0;
        if (!w_empty) w_steer[w_head] = regf_rd_data_avail;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_slot_vld   <= 1'b0;
            r_slot_req   <= '0;
            r_slot_owner <= '0;
            r_rr_ptr     <= '0;
        end else begin
            if (w_push) r_slot_vld <= 1'b0;
            if (w_grant) begin
                r_slot_vld   <= 1'b1;
                r_slot_req   <= req[w_gnt_idx];
                r_slot_owner <= w_gnt_idx;
                r_rr_ptr     <= (w_gnt_idx == OWN_W'(NREQ - 1)) ? '0 : w_gnt_idx + OWN_W'(1);
            end
        end
    end

    // NOTE: the owner storage has no reset; pointers and count are reset, so
    // stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) r_owner_mem[r_wr_ptr] <= r_slot_owner;
    end

    // A pop always reads the old head; a concurrent push writes the tail.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            r_rd_data_avail <= '0;
            r_rd_data       <= '0;
            r_rd_last_word  <= 1'b0;
            r_rd_is_body    <= 1'b0;
            r_rd_last_mask  <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_rd_data_avail <= w_steer;
            r_rd_data       <= regf_rd_data;
            r_rd_last_word  <= regf_rd_last_word;
            r_rd_is_body    <= regf_rd_is_body;
            r_rd_last_mask  <= regf_rd_last_mask;
            r_err           <= r_err || (w_empty && (|regf_rd_data_avail));
        end
    end

    assign regf_rd_req_vld = r_slot_vld;
    assign regf_rd_req     = r_slot_req;
    assign rd_data_avail   = r_rd_data_avail;
    assign rd_data         = r_rd_data;
    assign rd_last_word    = r_rd_last_word;
    assign rd_is_body      = r_rd_is_body;
    assign rd_last_mask    = r_rd_last_mask;
    assign err_unexp_data  = r_err;

endmodule

// File: tb/tb_pep_regf_rd_arb.sv
// Bench for pep_regf_rd_arb: queue-based owner model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pep_regf_rd_arb;

    localparam int NREQ  = 2;
    localparam int RW    = 16;
    localparam int CNB   = 4;
    localparam int QW    = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic a_rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]          req_vld = '0;
    logic [NREQ-1:0]          req_rdy;
    logic [NREQ-1:0][RW-1:0]  req = '0;
    logic                     regf_rd_req_vld;
    logic                     regf_rd_req_rdy = 1'b1;
    logic [RW-1:0]            regf_rd_req;
    logic [CNB-1:0]           regf_rd_data_avail = '0;
    logic [CNB-1:0][QW-1:0]   regf_rd_data = '0;
    logic                     regf_rd_last_word = 1'b0;
    logic                     regf_rd_is_body = 1'b0;
    logic                     regf_rd_last_mask = 1'b0;
    logic [NREQ-1:0][CNB-1:0] rd_data_avail;
    logic [CNB-1:0][QW-1:0]   rd_data;
    logic                     rd_last_word;
    logic                     rd_is_body;
    logic                     rd_last_mask;
    logic                     err_unexp_data;

    pep_regf_rd_arb #(
        .NREQ(NREQ), .REGF_RD_REQ_W(RW), .REGF_COEF_NB(CNB), .MOD_Q_W(QW), .OUTST_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req(req),
        .regf_rd_req_vld(regf_rd_req_vld), .regf_rd_req_rdy(regf_rd_req_rdy), .regf_rd_req(regf_rd_req),
        .regf_rd_data_avail(regf_rd_data_avail), .regf_rd_data(regf_rd_data),
        .regf_rd_last_word(regf_rd_last_word), .regf_rd_is_body(regf_rd_is_body),
        .regf_rd_last_mask(regf_rd_last_mask),
        .rd_data_avail(rd_data_avail), .rd_data(rd_data), .rd_last_word(rd_last_word),
        .rd_is_body(rd_is_body), .rd_last_mask(rd_last_mask), .err_unexp_data(err_unexp_data)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_mis++;
        $display("FAIL %s: event did not occur within its cycle budget (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit                       m_slot_vld = 0;
    logic [RW-1:0]            m_slot_req = '0;
    int                       m_slot_owner = 0;
    int                       m_rr = 0;
    int                       oq[$];
    bit                       m_err = 0;
    logic [NREQ-1:0][CNB-1:0] e_avail = '0;
    logic [CNB-1:0][QW-1:0]   e_data = '0;
    bit                       e_last = 0, e_body = 0, e_mask = 0;

    // Winner for the current inputs, or -1 when nobody may be granted.
    function automatic int pick();
        if (!a_rst_n || m_slot_vld || oq.size() >= DEPTH) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_vld[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or negedge a_rst_n);
        if (!a_rst_n) begin
            m_slot_vld = 0; m_slot_req = '0; m_slot_owner = 0; m_rr = 0;
            oq.delete(); m_err = 0; e_avail = '0; e_data = '0;
            e_last = 0; e_body = 0; e_mask = 0;
        end else begin
            int g;
            g = pick();
            e_avail = '0;
            if (|regf_rd_data_avail) begin
                if (oq.size() == 0) m_err = 1;
                else e_avail[oq[0]] = regf_rd_data_avail;
            end
            e_data = regf_rd_data;
            e_last = regf_rd_last_word; e_body = regf_rd_is_body; e_mask = regf_rd_last_mask;
            if (regf_rd_data_avail[0] && regf_rd_last_word && oq.size() > 0) void'(oq.pop_front());
            if (m_slot_vld && regf_rd_req_rdy) begin
                oq.push_back(m_slot_owner);
                m_slot_vld = 0;
            end
            if (g >= 0) begin
                m_slot_vld = 1; m_slot_req = req[g]; m_slot_owner = g; m_rr = (g + 1) % NREQ;
            end
        end
    end

    // ---------------- per-cycle compare and monitors ----------------
    int          gnt_q[$];
    logic [RW-1:0] rf_q[$];
    int          hs_cnt = 0;
    int          wcnt[NREQ];

    initial forever begin
        logic [NREQ-1:0] exp_rdy;
        int g;
        @(negedge clk);
        exp_rdy = '0;
        g = pick();
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_rdy", req_rdy, exp_rdy);
        check("regf_rd_req_vld", regf_rd_req_vld, m_slot_vld);
        if (m_slot_vld || !a_rst_n) check("regf_rd_req", regf_rd_req, m_slot_req);
        check("rd_data_avail", rd_data_avail, e_avail);
        check("rd_data", rd_data, e_data);
        check("sideband", {rd_last_word, rd_is_body, rd_last_mask}, {e_last, e_body, e_mask});
        check("err_unexp_data", err_unexp_data, m_err);
        if (a_rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_vld[i] && req_rdy[i]) gnt_q.push_back(i);
                if (rd_data_avail[i][0]) wcnt[i]++;
            end
            if (regf_rd_req_vld && regf_rd_req_rdy) begin
                hs_cnt++;
                rf_q.push_back(regf_rd_req);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_data();
        regf_rd_data_avail = '0; regf_rd_data = '0;
        regf_rd_last_word = 0; regf_rd_is_body = 0; regf_rd_last_mask = 0;
    endtask

    task automatic do_reset();
        a_rst_n = 0;
        req_vld = '0; req = '0; regf_rd_req_rdy = 1;
        clear_data();
        repeat (2) @(posedge clk);
        #1 a_rst_n = 1;
        gnt_q.delete(); rf_q.delete(); hs_cnt = 0;
        foreach (wcnt[i]) wcnt[i] = 0;
    endtask

    task automatic issue(input int i, input logic [RW-1:0] v);
        bit got;
        got = 0;
        req_vld[i] = 1'b1;
        req[i] = v;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = req_rdy[i];
            tick();
        end
        req_vld[i] = 1'b0;
        if (!got) fail_timeout("issue");
    endtask

    task automatic drive_word(input int w, input logic [15:0] base, input bit last);
        regf_rd_data_avail = '1;
        for (int c = 0; c < CNB; c++) regf_rd_data[c] = QW'(base + 16'(w * 4 + c));
        regf_rd_last_word = last;
        regf_rd_is_body = w[0];
        regf_rd_last_mask = last;
    endtask

    task automatic ret_words(input int n, input logic [15:0] base);
        for (int w = 0; w < n; w++) begin
            drive_word(w, base, w == n - 1);
            tick();
        end
        clear_data();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset state, with requests pending while reset is held.
        @(posedge clk); #1;
        req_vld = '1;
        @(negedge clk);
        check("reset req_rdy", req_rdy, 0);
        check("reset regf_rd_req_vld", regf_rd_req_vld, 0);
        check("reset rd_data_avail", rd_data_avail, 0);
        check("reset err", err_unexp_data, 0);

        // Single requester: 3 requests x 4 words.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(0, RW'(16'hA000 + k));
            tick(); tick();
            ret_words(4, 16'(16'h100 * k));
        end
        tick(); tick();
        check("t1 words req0", wcnt[0], 12);
        check("t1 words req1", wcnt[1], 0);
        check("t1 model fifo empty", oq.size(), 0);
        check("t1 err", err_unexp_data, 0);

        // Contention: both requesters held valid for 6 grants.
        do_reset();
        req[0] = 16'hA000; req[1] = 16'hB000; req_vld = 2'b11;
        fork
            begin
                int ng;
                int na[NREQ];
                ng = 0;
                foreach (na[i]) na[i] = 0;
                for (int n = 0; n < 200 && ng < 6; n++) begin
                    tick();
                    if (gnt_q.size() > ng) begin
                        int g;
                        ng = gnt_q.size();
                        g = gnt_q[$];
                        na[g]++;
                        req[g] = RW'((g == 0 ? 16'hA000 : 16'hB000) + na[g]);
                    end
                end
                req_vld = '0;
                if (ng < 6) fail_timeout("t2 grants");
            end
            begin
                for (int r = 0; r < 6; r++) begin
                    bit seen;
                    seen = 0;
                    for (int n = 0; n < 100 && !seen; n++) begin
                        if (hs_cnt > r) seen = 1;
                        else tick();
                    end
                    if (!seen) fail_timeout("t2 regfile handshake");
                    ret_words(2, 16'(16'h200 + 16'h10 * r));
                end
            end
        join
        tick(); tick();
        check("t2 grant count", gnt_q.size(), 6);
        if (gnt_q.size() >= 6 && rf_q.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("t2 grant %0d", k), gnt_q[k], k % 2);
                check($sformatf("t2 regfile order %0d", k), rf_q[k],
                      (k % 2 == 0) ? 16'hA000 + k / 2 : 16'hB000 + k / 2);
            end
        end
        check("t2 words req0", wcnt[0], 6);
        check("t2 words req1", wcnt[1], 6);

        // Backpressure: slot loaded, regfile not ready for 10 cycles.
        do_reset();
        regf_rd_req_rdy = 0;
        issue(0, 16'hC0DE);
        req[1] = 16'hB0B0; req_vld[1] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("t3 req stable", regf_rd_req, 16'hC0DE);
            check("t3 vld held", regf_rd_req_vld, 1);
            check("t3 req_rdy low", req_rdy, 0);
        end
        tick();
        regf_rd_req_rdy = 1; req_vld[1] = 1'b0;
        tick();
        check("t3 accepted once", hs_cnt, 1);
        check("t3 slot released", regf_rd_req_vld, 0);
        if (rf_q.size() > 0) check("t3 accepted value", rf_q[0], 16'hC0DE);

        // Full: 4 outstanding, a 5th must wait for the first request's last word.
        do_reset();
        for (int k = 0; k < 4; k++) issue(0, RW'(16'hD000 + k));
        tick(); tick();
        check("t4 model occupancy", oq.size(), 4);
        req[0] = 16'hD004; req_vld[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4 full req_rdy", req_rdy[0], 0);
        end
        tick();
        for (int w = 0; w < 4; w++) begin
            drive_word(w, 16'h300, w == 3);
            @(negedge clk);
            check("t4 req_rdy before pop", req_rdy[0], 0);
            tick();
        end
        clear_data();
        @(negedge clk);
        check("t4 req_rdy after pop", req_rdy[0], 1);
        tick();
        req_vld = '0;
        tick();

        // Simultaneous push and pop at occupancy 2.
        do_reset();
        issue(0, 16'hE000);
        issue(1, 16'hE100);
        tick(); tick();
        check("t5 model occupancy before", oq.size(), 2);
        issue(0, 16'hE200);
        drive_word(0, 16'h400, 1);
        tick();
        clear_data();
        check("t5 model occupancy after", oq.size(), 2);
        check("t5 steer head req0", rd_data_avail, 8'h0F);
        drive_word(0, 16'h410, 1);
        tick();
        clear_data();
        check("t5 steer next req1", rd_data_avail, 8'hF0);
        drive_word(0, 16'h420, 1);
        tick();
        clear_data();
        check("t5 steer pushed req0", rd_data_avail, 8'h0F);
        check("t5 no err yet", err_unexp_data, 0);
        drive_word(0, 16'h430, 1);
        tick();
        clear_data();
        check("t5 drained drop", rd_data_avail, 0);
        check("t5 drained err", err_unexp_data, 1);

        // Unexpected data with an empty FIFO, sticky error.
        do_reset();
        drive_word(0, 16'h500, 0);
        tick();
        clear_data();
        check("t6 dropped avail", rd_data_avail, 0);
        check("t6 err set", err_unexp_data, 1);
        repeat (5) tick();
        check("t6 err sticky", err_unexp_data, 1);

        // Reset asserted mid-transfer clears outputs immediately.
        do_reset();
        issue(0, 16'hF000);
        tick(); tick();
        drive_word(1, 16'h600, 0);
        tick();
        check("t6 transfer active", rd_data_avail, 8'h0F);
        req_vld[1] = 1'b1;
        #2 a_rst_n = 0;
        #1;
        check("t6 rst req_rdy", req_rdy, 0);
        check("t6 rst regf_rd_req_vld", regf_rd_req_vld, 0);
        check("t6 rst regf_rd_req", regf_rd_req, 0);
        check("t6 rst rd_data_avail", rd_data_avail, 0);
        check("t6 rst rd_data", rd_data, 0);
        check("t6 rst sideband", {rd_last_word, rd_is_body, rd_last_mask}, 0);
        check("t6 rst err", err_unexp_data, 0);
        req_vld = '0;
        clear_data();
        @(posedge clk);
        #1 a_rst_n = 1;
        drive_word(2, 16'h610, 1);
        tick();
        clear_data();
        check("t6 in-flight after reset err", err_unexp_data, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
